// File: rtl/systolic_pe.sv
// Weight-stationary systolic array processing element: int8 x int8 MAC into a
// 32-bit partial sum, with a double-buffered (shadow/active) weight register.
module systolic_pe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pe_psum_in,
  input  logic [7:0]  pe_weight_in,
  input  logic        pe_accept_w_in,
  input  logic [7:0]  pe_input_in,
  input  logic        pe_valid_in,
  input  logic        pe_switch_in,
  input  logic        pe_enabled,
  output logic [31:0] pe_psum_out,
  output logic [7:0]  pe_weight_out,
  output logic [7:0]  pe_input_out,
  output logic        pe_valid_out,
  output logic        pe_switch_out
);

  logic [7:0]  r_inactive_w;
  logic [7:0]  r_active_w;
  logic [31:0] r_psum;
  logic [7:0]  r_weight;
  logic [7:0]  r_input;
  logic        r_valid;
  logic        r_switch;

  logic signed [15:0] w_product;
  logic [31:0]        w_product_ext;
  logic [31:0]        w_mac;
  logic [31:0]        w_psum_next;

  // Product uses the pre-edge active weight, so a same-cycle switch cannot affect it.
  assign w_product     = $signed(pe_input_in) * $signed(r_active_w);
  assign w_product_ext = {{16{w_product[15]}}, w_product};
  assign w_mac         = w_product_ext + pe_psum_in;
  // Bubble cycles pass the north psum straight through, independent of pe_input_in.
  assign w_psum_next   = pe_valid_in ? w_mac : pe_psum_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inactive_w <= 8'd0;
      r_active_w   <= 8'd0;
      r_psum       <= 32'd0;
      r_weight     <= 8'd0;
      r_input      <= 8'd0;
      r_valid      <= 1'b0;
      r_switch     <= 1'b0;
    end else if (!pe_enabled) begin
      r_psum   <= 32'd0;
      r_weight <= 8'd0;
      r_input  <= 8'd0;
      r_valid  <= 1'b0;
      r_switch <= 1'b0;
    end else begin
      if (pe_accept_w_in) begin
        r_inactive_w <= pe_weight_in;
        r_weight     <= pe_weight_in;
      end else begin
        r_weight     <= 8'd0;
      end
      if (pe_switch_in) begin
        r_active_w <= r_inactive_w;
      end
      r_switch <= pe_switch_in;
      r_psum   <= w_psum_next;
      r_input  <= pe_input_in;
      r_valid  <= pe_valid_in;
    end
  end

  assign pe_psum_out   = r_psum;
  assign pe_weight_out = r_weight;
  assign pe_input_out  = r_input;
  assign pe_valid_out  = r_valid;
  assign pe_switch_out = r_switch;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed scoreboard bench for systolic_pe: the driver queues hand-computed
// expected outputs, a monitor pops and compares them after every clock edge.
module tb_systolic_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pe_psum_in;
  logic [7:0]  pe_weight_in;
  logic        pe_accept_w_in;
  logic [7:0]  pe_input_in;
  logic        pe_valid_in;
  logic        pe_switch_in;
  logic        pe_enabled;
  logic [31:0] pe_psum_out;
  logic [7:0]  pe_weight_out;
  logic [7:0]  pe_input_out;
  logic        pe_valid_out;
  logic        pe_switch_out;

  typedef struct {
    string       name;
    logic [31:0] psum;
    logic [7:0]  w;
    logic [7:0]  in;
    logic        v;
    logic        sw;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  systolic_pe dut (
    .clk            (clk),
    .rst            (rst),
    .pe_psum_in     (pe_psum_in),
    .pe_weight_in   (pe_weight_in),
    .pe_accept_w_in (pe_accept_w_in),
    .pe_input_in    (pe_input_in),
    .pe_valid_in    (pe_valid_in),
    .pe_switch_in   (pe_switch_in),
    .pe_enabled     (pe_enabled),
    .pe_psum_out    (pe_psum_out),
    .pe_weight_out  (pe_weight_out),
    .pe_input_out   (pe_input_out),
    .pe_valid_out   (pe_valid_out),
    .pe_switch_out  (pe_switch_out)
  );

  // Monitor: compares every field one time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (pe_psum_out !== e.psum) begin
        n_errors++;
        $display("FAIL %s psum_out: got %h expected %h", e.name, pe_psum_out, e.psum);
      end
      n_checks++;
      if (pe_weight_out !== e.w) begin
        n_errors++;
        $display("FAIL %s weight_out: got %h expected %h", e.name, pe_weight_out, e.w);
      end
      n_checks++;
      if (pe_input_out !== e.in) begin
        n_errors++;
        $display("FAIL %s input_out: got %h expected %h", e.name, pe_input_out, e.in);
      end
      n_checks++;
      if (pe_valid_out !== e.v) begin
        n_errors++;
        $display("FAIL %s valid_out: got %b expected %b", e.name, pe_valid_out, e.v);
      end
      n_checks++;
      if (pe_switch_out !== e.sw) begin
        n_errors++;
        $display("FAIL %s switch_out: got %b expected %b", e.name, pe_switch_out, e.sw);
      end
    end
  end

  task automatic step(
    input string       name,
    input logic        i_rst,
    input logic        i_en,
    input logic        i_acc,
    input logic [7:0]  i_w,
    input logic        i_sw,
    input logic        i_v,
    input logic [7:0]  i_in,
    input logic [31:0] i_psum,
    input logic [31:0] x_psum,
    input logic [7:0]  x_w,
    input logic [7:0]  x_in,
    input logic        x_v,
    input logic        x_sw
  );
    exp_t e;
    @(negedge clk);
    rst            = i_rst;
    pe_enabled     = i_en;
    pe_accept_w_in = i_acc;
    pe_weight_in   = i_w;
    pe_switch_in   = i_sw;
    pe_valid_in    = i_v;
    pe_input_in    = i_in;
    pe_psum_in     = i_psum;
    e.name = name;
    e.psum = x_psum;
    e.w    = x_w;
    e.in   = x_in;
    e.v    = x_v;
    e.sw   = x_sw;
    q.push_back(e);
  endtask

  initial begin
    int budget;
    rst            = 1'b1;
    pe_enabled     = 1'b1;
    pe_accept_w_in = 1'b0;
    pe_switch_in   = 1'b0;
    pe_valid_in    = 1'b0;
    pe_weight_in   = 'x;
    pe_input_in    = 'x;
    pe_psum_in     = 'x;

    //    name        rst en acc w      sw v  in     psum_in       exp_psum      w      in     v  sw
    step("reset0",    1, 1, 0, 'x,    0, 0, 'x,    'x,           32'd0,        8'd0,  8'd0,  0, 0);
    step("reset1",    1, 1, 0, 'x,    0, 0, 'x,    'x,           32'd0,        8'd0,  8'd0,  0, 0);
    step("load5",     0, 1, 1, 8'd5,  0, 0, 8'd0,  32'd0,        32'd0,        8'd5,  8'd0,  0, 0);
    step("mac_stale", 0, 1, 0, 8'd0,  0, 1, 8'd10, 32'd100,      32'd100,      8'd0,  8'd10, 1, 0);
    step("switch",    0, 1, 0, 8'd0,  1, 0, 8'd0,  32'd0,        32'd0,        8'd0,  8'd0,  0, 1);
    step("mac_w5",    0, 1, 0, 8'd0,  0, 1, 8'd20, 32'd7,        32'd107,      8'd0,  8'd20, 1, 0);
    step("bubble",    0, 1, 0, 8'd0,  0, 0, 8'h5A, 32'd999,      32'd999,      8'd0,  8'h5A, 0, 0);
    // Disabled cycle also tries to load 9 and switch; both must be ignored.
    step("disabled",  0, 0, 1, 8'd9,  1, 1, 8'd50, 32'd50,       32'd0,        8'd0,  8'd0,  0, 0);
    step("reenable",  0, 1, 0, 8'd0,  0, 1, 8'd1,  32'd0,        32'd5,        8'd0,  8'd1,  1, 0);
    step("sw_again",  0, 1, 0, 8'd0,  1, 0, 8'd0,  32'd0,        32'd0,        8'd0,  8'd0,  0, 1);
    step("shadow_ok", 0, 1, 0, 8'd0,  0, 1, 8'd1,  32'd0,        32'd5,        8'd0,  8'd1,  1, 0);
    step("load_m128", 0, 1, 1, 8'h80, 0, 0, 8'd0,  32'd0,        32'd0,        8'h80, 8'd0,  0, 0);
    step("sw_m128",   0, 1, 0, 8'd0,  1, 0, 8'd0,  32'd0,        32'd0,        8'd0,  8'd0,  0, 1);
    // -128*-128 + 0x7FFFFFFF wraps; same cycle loads 3 and switches (active stays -128).
    step("wrap_accsw",0, 1, 1, 8'd3,  1, 1, 8'h80, 32'h7FFFFFFF, 32'h80003FFF, 8'd3,  8'h80, 1, 1);
    step("old_shadow",0, 1, 0, 8'd0,  0, 1, 8'd1,  32'd0,        32'hFFFFFF80, 8'd0,  8'd1,  1, 0);
    step("sw_to3",    0, 1, 0, 8'd0,  1, 0, 8'd0,  32'd0,        32'd0,        8'd0,  8'd0,  0, 1);
    step("mac_w3",    0, 1, 0, 8'd0,  0, 1, 8'd2,  32'd10,       32'd16,       8'd0,  8'd2,  1, 0);
    step("neg_prod",  0, 1, 0, 8'd0,  0, 1, 8'hFD, 32'd0,        32'hFFFFFFF7, 8'd0,  8'hFD, 1, 0);
    step("neg_plus",  0, 1, 0, 8'd0,  0, 1, 8'hFD, 32'd100,      32'd91,       8'd0,  8'hFD, 1, 0);
    step("mid_reset", 1, 1, 1, 8'd7,  1, 1, 8'd4,  32'd1,        32'd0,        8'd0,  8'd0,  0, 0);
    step("post_rst",  0, 1, 0, 8'd0,  0, 1, 8'd4,  32'd1,        32'd1,        8'd0,  8'd4,  1, 0);
    step("post_sw",   0, 1, 0, 8'd0,  1, 0, 8'd0,  32'd0,        32'd0,        8'd0,  8'd0,  0, 1);
    step("post_mac",  0, 1, 0, 8'd0,  0, 1, 8'd4,  32'd1,        32'd1,        8'd0,  8'd4,  1, 0);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Single processing element of a weight-stationary systolic array for signed int8 matrix multiply with 32-bit accumulation. It holds a double-buffered weight: a shadow ("inactive") weight loaded from the north while the "active" weight drives the MAC. It also forwards activations east and partial sums south. Instances tile into a 2-D grid; the array top drives the north and west edges.

## Interface
- No parameters. Widths are fixed: activation/weight 8-bit signed, partial sum 32-bit signed.
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- pe_psum_in  in  32  signed partial sum from the north neighbour
- pe_weight_in  in  8  signed weight from the north, for the shadow buffer
- pe_accept_w_in  in  1  load strobe for pe_weight_in
- pe_input_in  in  8  signed activation from the west
- pe_valid_in  in  1  pe_input_in is valid this cycle
- pe_switch_in  in  1  copy the shadow weight into the active weight
- pe_enabled  in  1  PE enable; 0 forces outputs to zero
- pe_psum_out  out  32  signed partial sum to the south (registered)
- pe_weight_out  out  8  weight forwarded to the south (registered)
- pe_input_out  out  8  activation forwarded to the east (registered)
- pe_valid_out  out  1  valid forwarded to the east (registered)
- pe_switch_out  out  1  switch forwarded to the east (registered)

## Operation
- State: inactive_w[7:0] (shadow), active_w[7:0], plus the five output registers.
- Reset: when rst=1 at an edge, all state and outputs go to 0. Reset has priority over everything.
- Disabled: when pe_enabled=0 and rst=0, all five output registers load 0. inactive_w and active_w hold their values; accept and switch are ignored.
- Enabled behaviour at each edge:
  - Weight load: if pe_accept_w_in=1, inactive_w <= pe_weight_in and pe_weight_out <= pe_weight_in. Otherwise pe_weight_out <= 0.
  - Switch: if pe_switch_in=1, active_w <= inactive_w, using the pre-edge value. pe_switch_out <= pe_switch_in.
  - Accept and switch together: active_w takes the old inactive_w; inactive_w takes pe_weight_in.
  - MAC: if pe_valid_in=1, pe_psum_out <= sext32(pe_input_in * active_w) + pe_psum_in.
    - active_w here is the pre-edge value, so a switch in the same cycle does not affect this MAC.
  - Bubble: if pe_valid_in=0, pe_psum_out <= pe_psum_in unchanged.
  - Forwarding: pe_input_out <= pe_input_in and pe_valid_out <= pe_valid_in.
- Arithmetic:
  - 8x8 signed multiply gives an exact 16-bit product, sign-extended to 32 bits.
  - The 32-bit add wraps modulo 2^32; no saturation, no overflow flag.

## Timing
- Every output is registered, with exactly one cycle of latency from input to output.
- Reset release: outputs are 0 on the first edge after rst deasserts, until new inputs propagate.
- Weight path: a load at edge N makes the weight usable by a switch at edge N+1 or later. A MAC uses the new weight from the edge after the switch edge.
- Southward weight path: pe_weight_out is valid one cycle after the load and 0 in non-load cycles.
- Enable timing: pe_enabled is sampled at the edge. Outputs are 0 from the first edge with pe_enabled=0 and resume on the first edge with it at 1.
- Unknown inputs: input data, weight and psum may be X when their qualifier is low. pe_psum_out must not depend on pe_input_in when pe_valid_in=0.
- No handshake and no backpressure; the PE advances every cycle.

## Test plan
- Reset: hold rst 2 cycles with X data inputs -> all outputs 0; active_w=inactive_w=0.
- Load then MAC with stale active weight:
  - accept_w=1, weight_in=5 -> pe_weight_out=5 next cycle.
  - Then valid=1, input=10, psum_in=100 -> psum_out=100 (active_w still 0), valid_out=1, input_out=10.
- Switch then MAC: switch_in=1 for one cycle -> switch_out=1 next cycle. Then valid=1, input=20, psum_in=7 -> psum_out=107.
- Bubble passthrough: valid=0, input=X, psum_in=999 -> psum_out=999, valid_out=0.
- Disable: pe_enabled=0, valid=1, input=50, psum_in=50 -> all outputs 0. Re-enable with valid=1, input=1, psum_in=0 -> psum_out=5, showing the weight was retained.
- Signed wrap and same-cycle accept+switch:
  - active_w=-128, input=-128, psum_in=0x7FFFFFFF -> psum_out=0x80003FFF.
  - accept_w=1, weight_in=3 together with switch=1 -> active_w takes the old shadow value, shadow becomes 3.
